// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift issue controller:
//   - R-type function codes of the six supported shifts
//   - shifter mode encodings driven on sh_sel
//   - FSM state type
// ----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] SEL_SLL = 2'b00;
  localparam logic [1:0] SEL_SRL = 2'b01;
  localparam logic [1:0] SEL_SRA = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PASS1 = 3'd2,
    ST_PASS2 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/shift_funct_decode.sv
// ----------------------------------------------------------------------------
// shift_funct_decode
// Purely combinational decode of an R-type function code into shifter
// controls.
// Ports:
//   funct   in  [5:0]  function code
//   valid   out        funct is one of the six supported shifts
//   var_amt out        amount comes from rs[4:0] (SLLV/SRLV/SRAV)
//   sel     out [1:0]  shifter mode (00 left, 01 logical right, 10 arith right)
// ----------------------------------------------------------------------------
module shift_funct_decode
  import shift_pkg::*;
(
  input  logic [5:0] funct,
  output logic       valid,
  output logic       var_amt,
  output logic [1:0] sel
);

  always_comb begin
    valid   = 1'b1;
    var_amt = 1'b0;
    sel     = SEL_SLL;
    case (funct)
      FUNCT_SLL:  sel = SEL_SLL;
      FUNCT_SRL:  sel = SEL_SRL;
      FUNCT_SRA:  sel = SEL_SRA;
      FUNCT_SLLV: begin var_amt = 1'b1; sel = SEL_SLL; end
      FUNCT_SRLV: begin var_amt = 1'b1; sel = SEL_SRL; end
      FUNCT_SRAV: begin var_amt = 1'b1; sel = SEL_SRA; end
      default:    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_issue_ctrl.sv
// ----------------------------------------------------------------------------
// shift_issue_ctrl
// Sequences one shift operation through an external combinational shifter.
// A request is latched in IDLE, decoded in LOAD, driven onto the shifter in
// PASS1 (and PASS2 for rotates) for SHIFT_WAIT cycles each, and completed
// with a one-cycle done pulse in DONE.
//
// Optional feature: define SHIFT_ROTATE_EN to enable rotate-right (rot=1
// with SRL/SRLV), built as (rt >> s) | (rt << (32-s)) over two passes.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request, sampled only in IDLE
//   funct/shamt        R-type function code / immediate amount
//   rs_val/rt_val      variable amount source (bits [4:0]) / operand
//   rot                rotate request (only with SHIFT_ROTATE_EN)
//   sh_a/sh_b/sh_sel   shifter operand / amount / mode, zero outside passes
//   sh_out             shifter result
//   busy/done          not-IDLE flag / completion pulse
//   result/illegal     registered result / unsupported funct flag
// ----------------------------------------------------------------------------
module shift_issue_ctrl
  import shift_pkg::*;
#(
  parameter int SHIFT_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rot,
  output logic [31:0] sh_a,
  output logic [31:0] sh_b,
  output logic [1:0]  sh_sel,
  input  logic [31:0] sh_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal
);

  localparam logic [1:0] WAIT_LAST = 2'(SHIFT_WAIT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_funct;
  logic [4:0]  r_shamt;
  logic [4:0]  r_rs_amt;
  logic [31:0] r_rt;
  logic [1:0]  r_sel;
  logic [4:0]  r_s;
  logic [1:0]  r_wait;
  logic [31:0] r_result;
  logic        r_illegal;
  logic        w_valid;
  logic        w_var_amt;
  logic [1:0]  w_sel;
  logic        w_pass_last;
  logic        w_unused_rs;

`ifdef SHIFT_ROTATE_EN
  logic        r_rot;
  logic        r_is_rot;
  logic [31:0] r_p1;
  logic        w_rot_req;

  // Rotate is only meaningful on the logical-right codes; other codes drop rot.
  assign w_rot_req = r_rot && ((r_funct == FUNCT_SRL) || (r_funct == FUNCT_SRLV));
`else
  logic w_unused_rot;
  assign w_unused_rot = rot;
`endif

  assign w_unused_rs = &{1'b0, rs_val[31:5]};

  shift_funct_decode u_decode (
    .funct   (r_funct),
    .valid   (w_valid),
    .var_amt (w_var_amt),
    .sel     (w_sel)
  );

  assign w_pass_last = (r_wait == WAIT_LAST);
  assign result      = r_result;
  assign illegal     = r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    sh_a         = 32'd0;
    sh_b         = 32'd0;
    sh_sel       = SEL_SLL;
    busy         = (r_state != ST_IDLE);
    done         = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = w_valid ? ST_PASS1 : ST_DONE;
      ST_PASS1: begin
        sh_a   = r_rt;
        sh_b   = {27'd0, r_s};
        sh_sel = r_sel;
        if (w_pass_last) begin
`ifdef SHIFT_ROTATE_EN
          // A zero-amount rotate is already complete after the first pass.
          w_state_next = (r_is_rot && (r_s != 5'd0)) ? ST_PASS2 : ST_DONE;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
`ifdef SHIFT_ROTATE_EN
      ST_PASS2: begin
        sh_a   = r_rt;
        sh_b   = 32'd32 - {27'd0, r_s};
        sh_sel = SEL_SLL;
        if (w_pass_last) w_state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result and illegal are loaded on the edge entering DONE so they are valid
  // alongside the done pulse; an aborted operation never gets that far.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct   <= 6'd0;
      r_shamt   <= 5'd0;
      r_rs_amt  <= 5'd0;
      r_rt      <= 32'd0;
      r_sel     <= SEL_SLL;
      r_s       <= 5'd0;
      r_wait    <= 2'd0;
      r_result  <= 32'd0;
      r_illegal <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      r_rot     <= 1'b0;
      r_is_rot  <= 1'b0;
      r_p1      <= 32'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_funct   <= funct;
          r_shamt   <= shamt;
          r_rs_amt  <= rs_val[4:0];
          r_rt      <= rt_val;
          r_illegal <= 1'b0;
`ifdef SHIFT_ROTATE_EN
          r_rot     <= rot;
`endif
        end
        ST_LOAD: begin
          r_sel  <= w_sel;
          r_s    <= w_var_amt ? r_rs_amt : r_shamt;
          r_wait <= 2'd0;
`ifdef SHIFT_ROTATE_EN
          r_is_rot <= w_rot_req;
`endif
          if (!w_valid) begin
            r_result  <= 32'd0;
            r_illegal <= 1'b1;
          end
        end
        ST_PASS1: begin
          if (w_pass_last) begin
            r_wait <= 2'd0;
`ifdef SHIFT_ROTATE_EN
            r_p1 <= sh_out;
            if (!r_is_rot)           r_result <= sh_out;
            else if (r_s == 5'd0)    r_result <= r_rt;
`else
            r_result <= sh_out;
`endif
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
`ifdef SHIFT_ROTATE_EN
        ST_PASS2: begin
          if (w_pass_last) r_result <= r_p1 | sh_out;
          else             r_wait   <= r_wait + 2'd1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
